// File: rtl/mem_interface.sv
// Memory-side handshake adapter for a multicycle CPU. It registers one access at
// a time, holds the control unit with cpu_stall, and flags protocol errors.
module mem_interface #(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cpu_read,
  input  logic             cpu_write,
  input  logic [WIDTH-1:0] cpu_addr,
  input  logic [WIDTH-1:0] cpu_wdata,
  output logic [WIDTH-1:0] cpu_rdata,
  output logic             cpu_stall,
  output logic             cpu_done,
  output logic             mem_read,
  output logic             mem_write,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_input_ready,
  input  logic             mem_ack_output,
  output logic             err
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

  typedef enum logic [2:0] {IDLE, RD_WAIT, WR_WAIT, DONE, ERROR} state_t;

  typedef struct packed {
    logic             rd;
    logic             wr;
    logic [WIDTH-1:0] addr;
    logic [WIDTH-1:0] wdata;
  } mem_req_t;

  state_t           state, state_nxt;
  mem_req_t         req, req_nxt;
  logic [WIDTH-1:0] rdata, rdata_nxt;
  logic             err_q, err_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             hs;

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      state <= IDLE;
      req   <= '0;
      rdata <= '0;
      err_q <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      req   <= req_nxt;
      rdata <= rdata_nxt;
      err_q <= err_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    req_nxt   = req;
    rdata_nxt = rdata;
    err_nxt   = err_q;
    cnt_nxt   = cnt;
    hs        = (state == RD_WAIT) ? mem_input_ready : mem_ack_output;
    case (state)
      IDLE: begin
        // A read wins a read/write collision; the write is dropped and flagged.
        if (cpu_read) begin
          req_nxt.rd   = 1'b1;
          req_nxt.addr = cpu_addr;
          cnt_nxt      = '0;
          state_nxt    = RD_WAIT;
          if (cpu_write) err_nxt = 1'b1;
        end else if (cpu_write) begin
          req_nxt.wr    = 1'b1;
          req_nxt.addr  = cpu_addr;
          req_nxt.wdata = cpu_wdata;
          cnt_nxt       = '0;
          state_nxt     = WR_WAIT;
        end
      end
      RD_WAIT, WR_WAIT: begin
        if (hs) begin
          if (state == RD_WAIT) rdata_nxt = mem_rdata;
          req_nxt.rd = 1'b0;
          req_nxt.wr = 1'b0;
          state_nxt  = DONE;
        end else if (cnt == CNT_MAX) begin
          req_nxt.rd = 1'b0;
          req_nxt.wr = 1'b0;
          err_nxt    = 1'b1;
          state_nxt  = ERROR;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      DONE: state_nxt = IDLE;
      ERROR: begin
        req_nxt.rd = 1'b0;
        req_nxt.wr = 1'b0;
        err_nxt    = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stall drops in DONE so the control unit advances exactly once per access.
  assign cpu_stall = (state == ERROR) |
                     ((cpu_read | cpu_write) &
                      ((state == IDLE) | (state == RD_WAIT) | (state == WR_WAIT)));
  assign cpu_done  = (state == DONE);
  assign cpu_rdata = rdata;
  assign mem_read  = req.rd;
  assign mem_write = req.wr;
  assign mem_addr  = req.addr;
  assign mem_wdata = req.wdata;
  assign err       = err_q;

endmodule

// File: tb/tb_mem_interface.sv
// Bench for mem_interface: directed vector table, hand-built corner sequences,
// then random traffic checked against an access-level reference model.
module tb_mem_interface;
  localparam int W  = 16;
  localparam int TO = 4;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         cpu_read, cpu_write;
  logic [W-1:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic         cpu_stall, cpu_done;
  logic         mem_read, mem_write;
  logic [W-1:0] mem_addr, mem_wdata, mem_rdata;
  logic         mem_input_ready, mem_ack_output;
  logic         err;

  int checks = 0;
  int errors = 0;

  mem_interface #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .cpu_done(cpu_done),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_input_ready(mem_input_ready),
    .mem_ack_output(mem_ack_output), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h @%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: which access is outstanding, how long it has waited,
  // and whether the block has died from a timeout.
  int           m_kind;  // 0 none, 1 read outstanding, 2 write outstanding
  int           m_wait;
  bit           m_done, m_dead, m_err;
  logic [W-1:0] m_addr, m_wdata, m_rdata;

  task automatic model_reset();
    m_kind = 0; m_wait = 0; m_done = 0; m_dead = 0; m_err = 0;
    m_addr = '0; m_wdata = '0; m_rdata = '0;
  endtask

  task automatic model_step(input logic r, w, input logic [W-1:0] a, wd, md,
                            input logic rdy, ack);
    if (m_dead) return;
    if (m_done) begin
      m_done = 0;
    end else if (m_kind == 0) begin
      if (r) begin
        m_kind = 1; m_addr = a; m_wait = 0;
        if (w) m_err = 1;
      end else if (w) begin
        m_kind = 2; m_addr = a; m_wdata = wd; m_wait = 0;
      end
    end else if ((m_kind == 1 && rdy) || (m_kind == 2 && ack)) begin
      if (m_kind == 1) m_rdata = md;
      m_kind = 0; m_done = 1;
    end else if (m_wait >= TO) begin
      m_kind = 0; m_dead = 1; m_err = 1;
    end else begin
      m_wait++;
    end
  endtask

  task automatic check_model(input string tag);
    bit idle_like;
    bit stall_e;
    idle_like = (m_kind == 0) && !m_done && !m_dead;
    stall_e   = m_dead || ((cpu_read || cpu_write) && (idle_like || m_kind != 0));
    chk({tag, ".mem_read"},  {31'd0, mem_read},  {31'd0, m_kind == 1});
    chk({tag, ".mem_write"}, {31'd0, mem_write}, {31'd0, m_kind == 2});
    chk({tag, ".mem_addr"},  {16'd0, mem_addr},  {16'd0, m_addr});
    chk({tag, ".mem_wdata"}, {16'd0, mem_wdata}, {16'd0, m_wdata});
    chk({tag, ".cpu_rdata"}, {16'd0, cpu_rdata}, {16'd0, m_rdata});
    chk({tag, ".cpu_stall"}, {31'd0, cpu_stall}, {31'd0, stall_e});
    chk({tag, ".cpu_done"},  {31'd0, cpu_done},  {31'd0, m_done});
    chk({tag, ".err"},       {31'd0, err},       {31'd0, m_err});
  endtask

  // One cycle: drive on the falling edge, compare 1 ns later, then advance the model.
  task automatic cyc(input string tag, input logic rst, r, w,
                     input logic [W-1:0] a, wd, md, input logic rdy, ack);
    @(negedge clk);
    reset_n = rst; cpu_read = r; cpu_write = w; cpu_addr = a; cpu_wdata = wd;
    mem_rdata = md; mem_input_ready = rdy; mem_ack_output = ack;
    #1;
    if (rst) model_reset();
    check_model(tag);
    if (!rst) model_step(r, w, a, wd, md, rdy, ack);
  endtask

  task automatic do_reset();
    cyc("rst", 1'b1, 0, 0, '0, '0, '0, 0, 0);
    cyc("rst_rel", 1'b0, 0, 0, '0, '0, '0, 0, 0);
  endtask

  typedef struct {
    logic         r, w;
    logic [W-1:0] a, wd, md;
    logic         rdy, ack;
    logic         e_rd, e_wr, e_stall, e_done, e_err;
    logic [W-1:0] e_addr, e_wdata, e_rdata;
  } vec_t;

  function automatic vec_t mk(input logic r, w, input logic [W-1:0] a, wd, md,
                              input logic rdy, ack, e_rd, e_wr, e_stall, e_done, e_err,
                              input logic [W-1:0] e_addr, e_wdata, e_rdata);
    vec_t v;
    v.r = r; v.w = w; v.a = a; v.wd = wd; v.md = md; v.rdy = rdy; v.ack = ack;
    v.e_rd = e_rd; v.e_wr = e_wr; v.e_stall = e_stall; v.e_done = e_done; v.e_err = e_err;
    v.e_addr = e_addr; v.e_wdata = e_wdata; v.e_rdata = e_rdata;
    return v;
  endfunction

  vec_t tv[$];
  int   cnt_rd, cnt_wr, cnt_done;

  initial begin
    reset_n = 1'b1; cpu_read = 0; cpu_write = 0; cpu_addr = '0; cpu_wdata = '0;
    mem_rdata = '0; mem_input_ready = 0; mem_ack_output = 0;
    model_reset();

    // Directed table: 0-wait read then 3-wait write, then a stray handshake in IDLE.
    tv.push_back(mk(1,0,16'h0010,16'h0000,16'h0000,0,0, 0,0,1,0,0, 16'h0000,16'h0000,16'h0000));
    tv.push_back(mk(1,0,16'h0010,16'h0000,16'hA5C3,1,0, 1,0,1,0,0, 16'h0010,16'h0000,16'h0000));
    tv.push_back(mk(0,0,16'h0000,16'h0000,16'h0000,0,0, 0,0,0,1,0, 16'h0010,16'h0000,16'hA5C3));
    tv.push_back(mk(0,0,16'h0000,16'h0000,16'h0000,0,0, 0,0,0,0,0, 16'h0010,16'h0000,16'hA5C3));
    tv.push_back(mk(0,1,16'h0020,16'h1234,16'h0000,0,0, 0,0,1,0,0, 16'h0010,16'h0000,16'hA5C3));
    tv.push_back(mk(0,1,16'h0020,16'h1234,16'h0000,0,0, 0,1,1,0,0, 16'h0020,16'h1234,16'hA5C3));
    tv.push_back(mk(0,1,16'h0020,16'h1234,16'h0000,0,0, 0,1,1,0,0, 16'h0020,16'h1234,16'hA5C3));
    tv.push_back(mk(0,1,16'h0020,16'h1234,16'h0000,0,0, 0,1,1,0,0, 16'h0020,16'h1234,16'hA5C3));
    tv.push_back(mk(0,1,16'h0020,16'h1234,16'h0000,0,1, 0,1,1,0,0, 16'h0020,16'h1234,16'hA5C3));
    tv.push_back(mk(0,0,16'h0000,16'h0000,16'h0000,0,0, 0,0,0,1,0, 16'h0020,16'h1234,16'hA5C3));
    tv.push_back(mk(0,0,16'h0000,16'h0000,16'hFFFF,1,1, 0,0,0,0,0, 16'h0020,16'h1234,16'hA5C3));
    tv.push_back(mk(0,0,16'h0000,16'h0000,16'h0000,0,0, 0,0,0,0,0, 16'h0020,16'h1234,16'hA5C3));

    @(negedge clk);
    #1;
    chk("reset.mem_read", {31'd0, mem_read}, 32'd0);
    chk("reset.cpu_rdata", {16'd0, cpu_rdata}, 32'd0);
    chk("reset.err", {31'd0, err}, 32'd0);
    @(negedge clk);
    reset_n = 1'b0;

    foreach (tv[i]) begin
      @(negedge clk);
      cpu_read = tv[i].r; cpu_write = tv[i].w; cpu_addr = tv[i].a; cpu_wdata = tv[i].wd;
      mem_rdata = tv[i].md; mem_input_ready = tv[i].rdy; mem_ack_output = tv[i].ack;
      #1;
      chk($sformatf("vec%0d.mem_read", i),  {31'd0, mem_read},  {31'd0, tv[i].e_rd});
      chk($sformatf("vec%0d.mem_write", i), {31'd0, mem_write}, {31'd0, tv[i].e_wr});
      chk($sformatf("vec%0d.cpu_stall", i), {31'd0, cpu_stall}, {31'd0, tv[i].e_stall});
      chk($sformatf("vec%0d.cpu_done", i),  {31'd0, cpu_done},  {31'd0, tv[i].e_done});
      chk($sformatf("vec%0d.err", i),       {31'd0, err},       {31'd0, tv[i].e_err});
      chk($sformatf("vec%0d.mem_addr", i),  {16'd0, mem_addr},  {16'd0, tv[i].e_addr});
      chk($sformatf("vec%0d.mem_wdata", i), {16'd0, mem_wdata}, {16'd0, tv[i].e_wdata});
      chk($sformatf("vec%0d.cpu_rdata", i), {16'd0, cpu_rdata}, {16'd0, tv[i].e_rdata});
    end

    // Read/write collision: only the read runs, err latches.
    do_reset();
    cnt_wr = 0;
    cyc("conf0", 0, 1, 1, 16'h0030, 16'h5555, 16'h0000, 0, 0);
    cnt_wr += mem_write;
    cyc("conf1", 0, 1, 1, 16'h0030, 16'h5555, 16'h7777, 1, 0);
    cnt_wr += mem_write;
    chk("conf.mem_read", {31'd0, mem_read}, 32'd1);
    cyc("conf2", 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0);
    cnt_wr += mem_write;
    chk("conf.done", {31'd0, cpu_done}, 32'd1);
    chk("conf.rdata", {16'd0, cpu_rdata}, 32'h7777);
    chk("conf.err", {31'd0, err}, 32'd1);
    chk("conf.no_write", cnt_wr, 0);

    // Timeout: 5 wait cycles with no ready, then absorbing error.
    do_reset();
    cnt_rd = 0;
    cyc("to_req", 0, 1, 0, 16'h0040, 16'h0000, 16'h0000, 0, 0);
    for (int k = 0; k < TO + 1; k++) begin
      cyc("to_wait", 0, 1, 0, 16'h0040, 16'h0000, 16'h0000, 0, 0);
      cnt_rd += mem_read;
    end
    for (int k = 0; k < 4; k++) begin
      cyc("to_err", 0, 0, 0, 16'h0000, 16'h0000, 16'hDEAD, 1, 1);
      cnt_rd += mem_read;
      chk("to.stall", {31'd0, cpu_stall}, 32'd1);
      chk("to.err", {31'd0, err}, 32'd1);
    end
    chk("to.read_cycles", cnt_rd, TO + 1);
    chk("to.rdata", {16'd0, cpu_rdata}, 32'd0);

    // Reset in RD_WAIT clears strobes at once; a late ready is ignored.
    do_reset();
    cyc("rmr0", 0, 1, 0, 16'h0050, 16'h0000, 16'h0000, 0, 0);
    cyc("rmr1", 0, 1, 0, 16'h0050, 16'h0000, 16'h0000, 0, 0);
    chk("rmr.mem_read_before", {31'd0, mem_read}, 32'd1);
    cyc("rmr2", 1, 1, 0, 16'h0050, 16'h0000, 16'hBEEF, 1, 0);
    chk("rmr.mem_read_in_reset", {31'd0, mem_read}, 32'd0);
    chk("rmr.addr_in_reset", {16'd0, mem_addr}, 32'd0);
    cyc("rmr3", 0, 0, 0, 16'h0000, 16'h0000, 16'hBEEF, 1, 0);
    cyc("rmr4", 0, 0, 0, 16'h0000, 16'h0000, 16'hBEEF, 1, 0);
    chk("rmr.rdata", {16'd0, cpu_rdata}, 32'd0);
    chk("rmr.done", {31'd0, cpu_done}, 32'd0);

    // Back-to-back reads with the request held across DONE.
    do_reset();
    cnt_done = 0;
    cyc("b2b0", 0, 1, 0, 16'h0100, 16'h0000, 16'h0000, 0, 0);
    cyc("b2b1", 0, 1, 0, 16'h0100, 16'h0000, 16'h1111, 1, 0);
    cyc("b2b2", 0, 1, 0, 16'h0104, 16'h0000, 16'h0000, 0, 0);
    cnt_done += cpu_done;
    chk("b2b.rdata1", {16'd0, cpu_rdata}, 32'h1111);
    chk("b2b.stall_done", {31'd0, cpu_stall}, 32'd0);
    cyc("b2b3", 0, 1, 0, 16'h0104, 16'h0000, 16'h0000, 0, 0);
    cnt_done += cpu_done;
    chk("b2b.stall_new", {31'd0, cpu_stall}, 32'd1);
    cyc("b2b4", 0, 1, 0, 16'h0104, 16'h0000, 16'h2222, 1, 0);
    cnt_done += cpu_done;
    chk("b2b.addr2", {16'd0, mem_addr}, 32'h0104);
    cyc("b2b5", 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0);
    cnt_done += cpu_done;
    chk("b2b.rdata2", {16'd0, cpu_rdata}, 32'h2222);
    cyc("b2b6", 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0);
    cnt_done += cpu_done;
    chk("b2b.done_pulses", cnt_done, 2);

    // Random traffic against the model; reset now and then and after a timeout.
    do_reset();
    begin
      int dead_cycles = 0;
      for (int n = 0; n < 800; n++) begin
        logic rst;
        rst = (dead_cycles >= 3) || ($urandom_range(0, 149) == 0);
        cyc("rand", rst, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
            W'($urandom), W'($urandom), W'($urandom),
            $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
        dead_cycles = rst ? 0 : (m_dead ? dead_cycles + 1 : 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_interface.md
MEM_INTERFACE -- requirements
Module: mem_interface

Interface
REQ-001 Parameter WIDTH, default 16, SHALL set the data and address word width.
REQ-002 Parameter TIMEOUT, default 255, SHALL set the maximum wait cycles per memory access before error.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  SHALL be the reset, asynchronous and active-high (1 = reset asserted).
REQ-005 cpu_read  input  1  SHALL be the read request from the control unit (its readM).
REQ-006 cpu_write  input  1  SHALL be the write request from the control unit (its MemWrite).
REQ-007 cpu_addr  input  WIDTH  SHALL be the access address (PC or ALUOut, per IorD).
REQ-008 cpu_wdata  input  WIDTH  SHALL be the store data.
REQ-009 cpu_rdata  output  WIDTH  SHALL be the registered read data, feeding IR/MDR.
REQ-010 cpu_stall  output  1  SHALL freeze the control-unit stage register while an access is in progress.
REQ-011 cpu_done  output  1  SHALL pulse for one cycle on access completion.
REQ-012 mem_read / mem_write  output  1 each  SHALL be the registered memory strobes.
REQ-013 mem_addr / mem_wdata  output  WIDTH each  SHALL be the registered memory address and store data.
REQ-014 mem_rdata  input  WIDTH  SHALL be the memory read data.
REQ-015 mem_input_ready  input  1  SHALL indicate mem_rdata is valid for the current read.
REQ-016 mem_ack_output  input  1  SHALL indicate the current write has been accepted.
REQ-017 err  output  1  SHALL be a sticky timeout/protocol error flag.

Function
REQ-018 The FSM SHALL have states IDLE, RD_WAIT, WR_WAIT, DONE, and ERROR.
REQ-019 IDLE with cpu_read=1 SHALL latch cpu_addr into mem_addr, set mem_read=1, clear the wait counter, and go to RD_WAIT.
REQ-020 IDLE with cpu_write=1 and cpu_read=0 SHALL latch cpu_addr and cpu_wdata, set mem_write=1, clear the wait counter, and go to WR_WAIT.
REQ-021 If cpu_read and cpu_write are both 1 in IDLE, the read SHALL be served, the write SHALL be dropped, and err SHALL be set.
REQ-022 In RD_WAIT, mem_input_ready=1 SHALL capture mem_rdata into cpu_rdata, clear mem_read, and go to DONE.
REQ-023 In WR_WAIT, mem_ack_output=1 SHALL clear mem_write and go to DONE.
REQ-024 A handshake input sampled in the same cycle the strobe is first driven SHALL count; minimum request-to-done latency SHALL be 2 cycles (IDLE->WAIT->DONE).
REQ-025 In RD_WAIT/WR_WAIT without the handshake, the wait counter SHALL increment; when it equals TIMEOUT, both strobes SHALL clear, err SHALL set, and the FSM SHALL go to ERROR.
REQ-026 DONE SHALL last exactly one cycle with cpu_done=1, then return to IDLE unconditionally.
REQ-027 cpu_stall SHALL be combinational: 1 when (cpu_read|cpu_write)=1 and state is IDLE, RD_WAIT, or WR_WAIT; 1 always in ERROR; 0 otherwise.
REQ-028 In DONE, cpu_stall=0 SHALL let the control unit advance its stage on that edge; a request still asserted in the following IDLE cycle SHALL be treated as a new access.
REQ-029 ERROR SHALL be absorbing until reset: strobes 0, cpu_stall=1, err=1.
REQ-030 cpu_rdata SHALL hold its value until the next completed read; writes SHALL not alter it.
REQ-031 Handshake inputs arriving in IDLE, DONE, or ERROR SHALL be ignored.
REQ-032 The wait counter SHALL be ceil(log2(TIMEOUT+1)) bits and SHALL never wrap.

Reset
REQ-033 While reset_n=1, the block SHALL be in state IDLE with mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, cpu_rdata=0, cpu_done=0, err=0, and counter=0, asynchronously and mid-access included.
REQ-034 After reset release, the first rising edge SHALL evaluate IDLE normally; an aborted access SHALL not be resumed.

Verification
REQ-035 Read, 0-wait: cpu_read=1, addr=0x0010, mem_input_ready=1 with rdata=0xA5C3 in RD_WAIT -> cpu_done at cycle 2, cpu_rdata=0xA5C3, stall 1 then 0.
REQ-036 Write, 3-wait: cpu_write=1, addr=0x0020, wdata=0x1234, ack after 3 cycles -> mem_write high 4 cycles, mem_wdata=0x1234, single cpu_done pulse, cpu_rdata unchanged.
REQ-037 Timeout: read with TIMEOUT=4 and no ready -> err=1, mem_read=0 after 5 wait cycles, cpu_stall stuck at 1 until reset.
REQ-038 Conflict: cpu_read=cpu_write=1 -> only mem_read asserted, err=1, read completes normally.
REQ-039 Reset mid-read: reset_n=1 during RD_WAIT -> strobes 0 immediately, state IDLE; a late mem_input_ready does not update cpu_rdata.
REQ-040 Back-to-back: IF read then LWD read with request held -> two separate cpu_done pulses, each with its own captured data.
